trng_word_ctrl: RTL and testbench

Sequencer for the TRNG word-assembly shift register. On a start command it streams a programmed number of Bpc-bit entropy chunks into the shift register and collects each completed Dbw-bit word into a small FIFO. It runs a repetition health test on consecutive words and presents the words on a valid/ready stream to the AXI4-Lite register front end.

---
 rtl/trng_pkg.sv | 28 ++
 rtl/trng_word_ctrl_if.sv | 14 +
 rtl/trng_word_fifo.sv | 67 ++++++
 rtl/trng_word_ctrl.sv | 157 +++++++++++++++
 tb/tb_trng_word_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG word-assembly controller.
//   - Controller state encoding (kept as plain 2-bit constants for legacy tools).
//   - Chunks-per-word computation.
//   - Legality checks for the word width and chunk width parameters.
package trng_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFill  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StError = 2'd3;

    function automatic int unsigned calc_cpw(input int unsigned dbw, input int unsigned bpc);
        return dbw / bpc;
    endfunction

    function automatic bit dbw_ok(input int unsigned dbw);
        return (dbw == 32) || (dbw == 64);
    endfunction

    function automatic bit bpc_ok(input int unsigned bpc);
        return (bpc == 2) || (bpc == 4);
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/trng_word_ctrl_if.sv
// Output word stream between the TRNG controller and the register front end.
//   out_data  : head word (driven by master)
//   out_valid : a word is available (driven by master)
//   out_ready : consumer takes the head word this cycle (driven by slave)
interface trng_word_ctrl_if #(
    parameter int unsigned DBW = 32
) ();
    logic [DBW-1:0] out_data;
    logic           out_valid;
    logic           out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/trng_word_fifo.sv
// First-word fall-through synchronous FIFO for assembled TRNG words.
//   clock, reset : system clock, synchronous active-high reset
//   flush        : empties the FIFO (pointers and count to zero)
//   push/push_data : write one word; ignored when full
//   pop          : drop the head word; ignored when empty
//   pop_data     : head word, 0 while empty
//   full/empty/count : occupancy status
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int unsigned DBW        = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DBW-1:0]                push_data,
    input  logic                          pop,
    output logic [DBW-1:0]                pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("trng_word_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [DBW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push, do_pop;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Storage needs no reset; the empty flag masks stale entries.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/trng_word_ctrl.sv
// TRNG word-assembly sequencer.
// On start it issues num_words*CPW entropy chunks to the shift register, captures each
// completed word into a FWFT FIFO, runs a repetition-count health test on consecutive
// words and presents the words on the out_if valid/ready stream.
//   clock, reset        : system clock, synchronous active-high reset
//   start, num_words    : launch a run of num_words words (0 = empty run, done only)
//   clear_err           : leave ERROR, clear rct_fail, flush FIFO
//   ent_valid           : a fresh entropy chunk is available
//   sr_en, sr_ready     : chunk shift enable / word-consumed acknowledge
//   sr_word, sr_valid   : assembled word from the shift register
//   out_if (master)     : output word stream
//   busy, done, rct_fail: status
module trng_word_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned DBW        = 32,
    parameter int unsigned BPC        = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_words,
    input  logic                  clear_err,
    input  logic                  ent_valid,
    output logic                  sr_en,
    output logic                  sr_ready,
    input  logic [DBW-1:0]        sr_word,
    input  logic                  sr_valid,
    trng_word_ctrl_if.master      out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  rct_fail
);
    localparam int unsigned CPW = calc_cpw(DBW, BPC);
    localparam int unsigned CW  = CNT_W + $clog2(CPW);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    if (!dbw_ok(DBW)) begin : g_bad_dbw
        $error("trng_word_ctrl: DBW must be 32 or 64");
    end
    if (!bpc_ok(BPC)) begin : g_bad_bpc
        $error("trng_word_ctrl: BPC must be 2 or 4");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    target_q, chunks_q;
    logic [CNT_W-1:0] nwords_q, words_q;
    logic [DBW-1:0]   prev_word_q;
    logic             prev_valid_q, rct_fail_q, zero_done_q;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic [FCW-1:0]   fifo_count;
    logic [DBW-1:0]   fifo_head;
    logic             in_run, capture, repeat_hit, rct_trip, stall, last_push;
    logic             launch, drain_exit;

    assign in_run     = (state_q == StFill) || (state_q == StDrain);
    assign capture    = sr_valid & ~fifo_full & in_run;
    assign repeat_hit = prev_valid_q && (sr_word == prev_word_q);
    // A repeated word is still consumed from the shift register but never stored.
    assign rct_trip   = capture & repeat_hit;
    assign fifo_push  = capture & ~repeat_hit;
    assign stall      = sr_valid & ~capture;
    assign last_push  = fifo_push && (words_q == nwords_q - CNT_W'(1));
    assign launch     = (state_q == StIdle) && start && (num_words != '0);
    assign drain_exit = (state_q == StDrain) && fifo_empty && !capture;

    assign sr_ready   = capture;
    assign sr_en      = (state_q == StFill) && ent_valid && (chunks_q < target_q) && !stall;
    assign fifo_pop   = out_if.out_valid & out_if.out_ready;
    assign fifo_flush = (state_q == StError) && clear_err;

    assign out_if.out_valid = (fifo_count != '0);
    assign out_if.out_data  = fifo_head;
    assign busy     = (state_q != StIdle);
    assign done     = drain_exit | zero_done_q;
    assign rct_fail = rct_fail_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (launch) state_d = StFill;
            StFill: begin
                if (rct_trip) begin
                    state_d = StError;
                end else if (last_push) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (rct_trip) begin
                    state_d = StError;
                end else if (drain_exit) begin
                    state_d = StIdle;
                end
            end
            StError: if (clear_err) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            target_q     <= '0;
            chunks_q     <= '0;
            nwords_q     <= '0;
            words_q      <= '0;
            prev_word_q  <= '0;
            prev_valid_q <= 1'b0;
            rct_fail_q   <= 1'b0;
            zero_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= (state_q == StIdle) && start && (num_words == '0);
            if (launch) begin
                target_q     <= CW'(num_words) * CW'(CPW);
                nwords_q     <= num_words;
                chunks_q     <= '0;
                words_q      <= '0;
                prev_valid_q <= 1'b0;
            end else begin
                if (sr_en) begin
                    chunks_q <= chunks_q + CW'(1);
                end
                if (fifo_push) begin
                    words_q      <= words_q + CNT_W'(1);
                    prev_word_q  <= sr_word;
                    prev_valid_q <= 1'b1;
                end
            end
            if (rct_trip) begin
                rct_fail_q <= 1'b1;
            end else if (fifo_flush) begin
                rct_fail_q <= 1'b0;
            end
        end
    end

    trng_word_fifo #(
        .DBW        (DBW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (sr_word),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_trng_word_ctrl.sv
// Directed bench for trng_word_ctrl: a 32/4 instance and a 64/2 instance, each fed by a
// behavioural shift-register model that completes a word every CPW accepted chunks.
module tb_trng_word_ctrl;
    localparam int unsigned CPW32 = 8;
    localparam int unsigned CPW64 = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // 32-bit instance
    logic        start32 = 1'b0, clr32 = 1'b0, ent32 = 1'b0;
    logic [7:0]  num32 = '0;
    logic        sr_en32, sr_ready32, sr_valid32, busy32, done32, rct32;
    logic [31:0] sr_word32;
    trng_word_ctrl_if #(.DBW(32)) if32 ();

    // 64-bit instance
    logic        start64 = 1'b0, clr64 = 1'b0, ent64 = 1'b0;
    logic [7:0]  num64 = '0;
    logic        sr_en64, sr_ready64, sr_valid64, busy64, done64, rct64;
    logic [63:0] sr_word64;
    trng_word_ctrl_if #(.DBW(64)) if64 ();

    trng_word_ctrl #(.DBW(32), .BPC(4), .FIFO_DEPTH(4), .CNT_W(8)) u_dut32 (
        .clock(clock), .reset(reset), .start(start32), .num_words(num32),
        .clear_err(clr32), .ent_valid(ent32), .sr_en(sr_en32), .sr_ready(sr_ready32),
        .sr_word(sr_word32), .sr_valid(sr_valid32), .out_if(if32),
        .busy(busy32), .done(done32), .rct_fail(rct32)
    );

    trng_word_ctrl #(.DBW(64), .BPC(2), .FIFO_DEPTH(4), .CNT_W(8)) u_dut64 (
        .clock(clock), .reset(reset), .start(start64), .num_words(num64),
        .clear_err(clr64), .ent_valid(ent64), .sr_en(sr_en64), .sr_ready(sr_ready64),
        .sr_word(sr_word64), .sr_valid(sr_valid64), .out_if(if64),
        .busy(busy64), .done(done64), .rct_fail(rct64)
    );

    // Shift-register models: word value is a tagged sequence number, or a fixed
    // pattern when dup32 is set.
    int seq32 = 0, cnt32 = 0, seq64 = 0, cnt64 = 0;
    bit dup32 = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            cnt32 <= 0; seq32 <= 0; sr_valid32 <= 1'b0; sr_word32 <= '0;
        end else begin
            if (sr_ready32) sr_valid32 <= 1'b0;
            if (sr_en32) begin
                if (cnt32 == CPW32 - 1) begin
                    cnt32      <= 0;
                    seq32      <= seq32 + 1;
                    sr_valid32 <= 1'b1;
                    sr_word32  <= dup32 ? 32'hA5A5_A5A5 : (32'hC0DE_0000 | 32'(seq32));
                end else begin
                    cnt32 <= cnt32 + 1;
                end
            end
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            cnt64 <= 0; seq64 <= 0; sr_valid64 <= 1'b0; sr_word64 <= '0;
        end else begin
            if (sr_ready64) sr_valid64 <= 1'b0;
            if (sr_en64) begin
                if (cnt64 == CPW64 - 1) begin
                    cnt64      <= 0;
                    seq64      <= seq64 + 1;
                    sr_valid64 <= 1'b1;
                    sr_word64  <= 64'hFEED_0000_0000_0000 | 64'(seq64);
                end else begin
                    cnt64 <= cnt64 + 1;
                end
            end
        end
    end

    // Monitor on the falling edge.
    int cyc = 0, en32 = 0, en64 = 0, en64_bad = 0, ndone32 = 0, ndone64 = 0;
    int last_pop32 = 0, done_cyc32 = 0;
    logic [31:0] got32 [$];
    logic [63:0] got64 [$];

    always @(negedge clock) begin
        cyc++;
        if (sr_en32) en32++;
        if (sr_en64) en64++;
        if (sr_en64 && !ent64) en64_bad++;
        if (if32.out_valid && if32.out_ready) begin
            got32.push_back(if32.out_data);
            last_pop32 = cyc;
        end
        if (if64.out_valid && if64.out_ready) got64.push_back(if64.out_data);
        if (done32) begin ndone32++; done_cyc32 = cyc; end
        if (done64) ndone64++;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_32(input logic [7:0] n);
        start32 = 1'b1;
        num32   = n;
        tick(1);
        start32 = 1'b0;
    endtask

    task automatic wait_idle32(input string tag, input int budget);
        int k = 0;
        while (busy32 && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_idle"}, 64'(busy32), 64'd0);
    endtask

    task automatic check_reset32(input string tag);
        check({tag, "_sr_en"},    64'(sr_en32), 64'd0);
        check({tag, "_sr_ready"}, 64'(sr_ready32), 64'd0);
        check({tag, "_out_valid"}, 64'(if32.out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(if32.out_data), 64'd0);
        check({tag, "_busy"},     64'(busy32), 64'd0);
        check({tag, "_done"},     64'(done32), 64'd0);
        check({tag, "_rct"},      64'(rct32), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, g0, d0, k;
        if32.out_ready = 1'b0;
        if64.out_ready = 1'b0;
        ent32 = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_reset32("rst");
        check("rst64_busy", 64'(busy64), 64'd0);
        check("rst64_out_valid", 64'(if64.out_valid), 64'd0);

        // Plain run of three words with a always-ready consumer.
        if32.out_ready = 1'b1;
        e0 = en32; g0 = got32.size(); d0 = ndone32;
        start_32(8'd3);
        wait_idle32("t1", 200);
        check("t1_chunks", 64'(en32 - e0), 64'd24);
        check("t1_nwords", 64'(got32.size() - g0), 64'd3);
        for (int i = 0; i < 3 && g0 + i < got32.size(); i++)
            check("t1_word", 64'(got32[g0+i]), 64'hC0DE_0000 + 64'(i));
        check("t1_done_lat", 64'(done_cyc32 - last_pop32), 64'd1);
        check("t1_done_cnt", 64'(ndone32 - d0), 64'd1);
        tick(2);

        // Backpressure: four words fill the FIFO, a fifth waits in the shift register.
        if32.out_ready = 1'b0;
        e0 = en32; g0 = got32.size();
        start_32(8'd6);
        tick(80);
        check("t2_chunks_stalled", 64'(en32 - e0), 64'd40);
        check("t2_sr_en_low", 64'(sr_en32), 64'd0);
        check("t2_out_valid", 64'(if32.out_valid), 64'd1);
        check("t2_head", 64'(if32.out_data), 64'hC0DE_0003);
        check("t2_busy", 64'(busy32), 64'd1);
        tick(10);
        check("t2_chunks_hold", 64'(en32 - e0), 64'd40);
        if32.out_ready = 1'b1;
        wait_idle32("t2", 200);
        check("t2_chunks_total", 64'(en32 - e0), 64'd48);
        check("t2_nwords", 64'(got32.size() - g0), 64'd6);
        for (int i = 0; i < 6 && g0 + i < got32.size(); i++)
            check("t2_word", 64'(got32[g0+i]), 64'hC0DE_0003 + 64'(i));
        tick(2);

        // Repetition failure: two identical words in a row.
        if32.out_ready = 1'b0;
        dup32 = 1'b1;
        e0 = en32; d0 = ndone32;
        start_32(8'd2);
        k = 0;
        while (!rct32 && k < 100) begin tick(1); k++; end
        tick(1);
        check("t3_rct", 64'(rct32), 64'd1);
        check("t3_busy", 64'(busy32), 64'd1);
        check("t3_out_valid", 64'(if32.out_valid), 64'd1);
        check("t3_head", 64'(if32.out_data), 64'hA5A5_A5A5);
        check("t3_sr_ready", 64'(sr_ready32), 64'd0);
        start_32(8'd1);
        tick(3);
        check("t3_start_ignored", 64'(rct32), 64'd1);
        check("t3_sr_en_low", 64'(sr_en32), 64'd0);
        check("t3_chunks", 64'(en32 - e0), 64'd16);
        dup32 = 1'b0;
        clr32 = 1'b1;
        tick(1);
        clr32 = 1'b0;
        check("t3_clr_rct", 64'(rct32), 64'd0);
        check("t3_clr_out_valid", 64'(if32.out_valid), 64'd0);
        check("t3_clr_busy", 64'(busy32), 64'd0);
        check("t3_no_done", 64'(ndone32 - d0), 64'd0);
        tick(2);

        // Reset in the middle of FILL.
        if32.out_ready = 1'b1;
        e0 = en32;
        start_32(8'd2);
        k = 0;
        while ((en32 - e0) < 10 && k < 100) begin tick(1); k++; end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_reset32("t4");
        tick(1);
        e0 = en32; g0 = got32.size();
        start_32(8'd1);
        wait_idle32("t4", 100);
        check("t4_chunks", 64'(en32 - e0), 64'd8);
        check("t4_nwords", 64'(got32.size() - g0), 64'd1);
        if (got32.size() > g0) check("t4_word", 64'(got32[g0]), 64'hC0DE_0000);
        tick(2);

        // Zero-word run, then a start pulse while busy.
        e0 = en32; d0 = ndone32;
        start32 = 1'b1;
        num32   = 8'd0;
        tick(1);
        start32 = 1'b0;
        check("t5_done_pulse", 64'(done32), 64'd1);
        check("t5_busy", 64'(busy32), 64'd0);
        tick(1);
        check("t5_done_once", 64'(done32), 64'd0);
        tick(2);
        check("t5_done_cnt", 64'(ndone32 - d0), 64'd1);
        check("t5_chunks", 64'(en32 - e0), 64'd0);
        e0 = en32; g0 = got32.size();
        start_32(8'd2);
        tick(3);
        start_32(8'd5);
        wait_idle32("t5", 200);
        check("t5_busy_chunks", 64'(en32 - e0), 64'd16);
        check("t5_busy_nwords", 64'(got32.size() - g0), 64'd2);
        for (int i = 0; i < 2 && g0 + i < got32.size(); i++)
            check("t5_word", 64'(got32[g0+i]), 64'hC0DE_0001 + 64'(i));

        // 64-bit / 2-bit chunks with entropy valid every other cycle.
        if64.out_ready = 1'b1;
        e0 = en64; g0 = got64.size(); d0 = ndone64;
        start64 = 1'b1;
        num64   = 8'd2;
        tick(1);
        start64 = 1'b0;
        k = 0;
        while (busy64 && k < 400) begin
            ent64 = ~ent64;
            tick(1);
            k++;
        end
        ent64 = 1'b0;
        check("t6_idle", 64'(busy64), 64'd0);
        check("t6_chunks", 64'(en64 - e0), 64'd64);
        check("t6_en_gated", 64'(en64_bad), 64'd0);
        check("t6_nwords", 64'(got64.size() - g0), 64'd2);
        for (int i = 0; i < 2 && g0 + i < got64.size(); i++)
            check("t6_word", got64[g0+i], 64'hFEED_0000_0000_0000 + 64'(i));
        check("t6_done_cnt", 64'(ndone64 - d0), 64'd1);
        check("t6_rct", 64'(rct64), 64'd0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
